// File: rtl/minilogix2_pkg.sv
// minilogix2_pkg: shared widths, config field offsets and FSM state type
// for the minilogix2 LUT fabric.
package minilogix2_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Source-select width: primary inputs plus cell q values.
  function automatic int unsigned sel_width(input int unsigned nin, input int unsigned ncell);
    return clog2(nin + ncell);
  endfunction

  function automatic int unsigned osel_width(input int unsigned ncell);
    return clog2(ncell);
  endfunction

  // Bits per cell: K selects, 2^K truth table, ff_en.
  function automatic int unsigned cell_bits(input int unsigned k, input int unsigned selw);
    return k * selw + (32'd1 << k) + 1;
  endfunction

  function automatic int unsigned cfg_bits(input int unsigned ncell, input int unsigned cb,
                                           input int unsigned nout, input int unsigned osw);
    return ncell * cb + nout * osw;
  endfunction

  // Offsets within one cell slice.
  function automatic int unsigned sel_lo(input int unsigned k, input int unsigned selw);
    return k * selw;
  endfunction

  function automatic int unsigned tt_lo(input int unsigned k, input int unsigned selw);
    return k * selw;
  endfunction

  function automatic int unsigned ffen_bit(input int unsigned cb);
    return cb - 1;
  endfunction

  // Offset of output j select within the whole config word.
  function automatic int unsigned osel_lo(input int unsigned j, input int unsigned ncell,
                                          input int unsigned cb, input int unsigned osw);
    return ncell * cb + j * osw;
  endfunction

endpackage

// File: rtl/minilogix2_cell.sv
// minilogix2_cell: one K-input LUT with optional output flop. Decodes its
// own config slice and hands the source selects back to the fabric router.
module minilogix2_cell
  import minilogix2_pkg::*;
#(
  parameter int unsigned K    = 3,
  parameter int unsigned SELW = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [K-1:0]                    src,
  input  logic [cell_bits(K, SELW)-1:0]   cfg,
  output logic [K*SELW-1:0]               sel,
  output logic                            q,
  output logic                            out
);

  localparam int unsigned CB = cell_bits(K, SELW);

  logic [(1<<K)-1:0] truth;
  logic              ff_en;
  logic              comb;

  assign sel   = cfg[sel_lo(0, SELW) +: K*SELW];
  assign truth = cfg[tt_lo(K, SELW) +: (1<<K)];
  assign ff_en = cfg[ffen_bit(CB)];
  assign comb  = truth[src];

  // Cell flop samples the LUT result every cycle regardless of ff_en.
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= comb;
  end

  // Registered or combinational cell output.
  always_comb begin
    out = ff_en ? q : comb;
  end

endmodule

// File: rtl/minilogix2.sv
// minilogix2: LUT fabric top with serial double-buffered configuration.
// Optional readback of the active config on o_load_dat: MINILOGIX2_READBACK_EN.
module minilogix2
  import minilogix2_pkg::*;
#(
  parameter int unsigned NIN   = 8,
  parameter int unsigned NOUT  = 8,
  parameter int unsigned NCELL = 16,
  parameter int unsigned K     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIN-1:0]  i_input,
  output logic [NOUT-1:0] o_output,
  input  logic            i_load_en,
  input  logic            i_load_clk,
  input  logic            i_load_dat,
  output logic            o_load_dat,
  output logic            o_cfg_valid,
  output logic            o_cfg_err
);

  localparam int unsigned SELW     = sel_width(NIN, NCELL);
  localparam int unsigned OSW      = osel_width(NCELL);
  localparam int unsigned CB       = cell_bits(K, SELW);
  localparam int unsigned CFG_BITS = cfg_bits(NCELL, CB, NOUT, OSW);
  localparam int unsigned CNTW     = clog2(CFG_BITS + 2);
  localparam int unsigned NSRC     = NIN + NCELL;
  localparam int unsigned SPOOL    = 1 << SELW;
  localparam int unsigned OPOOL    = 1 << OSW;

  logic [1:0]          en_sync, clk_sync, dat_sync;
  logic                en_d, clk_d;
  logic                en_s, en_rise, clk_rise, dat_s;
  state_t              state, state_nxt;
  logic                start, shift, do_commit, bad_len;
  logic [CNTW-1:0]     cnt;
  logic [CFG_BITS-1:0] shadow, active;
  logic [NCELL-1:0]    cell_q, cell_out;
  logic [SPOOL-1:0]    src_pool;
  logic [OPOOL-1:0]    out_pool;

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_sync  <= '0;
      clk_sync <= '0;
      dat_sync <= '0;
      en_d     <= 1'b0;
      clk_d    <= 1'b0;
    end else begin
      en_sync  <= {en_sync[0], i_load_en};
      clk_sync <= {clk_sync[0], i_load_clk};
      dat_sync <= {dat_sync[0], i_load_dat};
      en_d     <= en_sync[1];
      clk_d    <= clk_sync[1];
    end
  end

  assign en_s     = en_sync[1];
  assign dat_s    = dat_sync[1];
  assign en_rise  = en_s & ~en_d;
  assign clk_rise = clk_sync[1] & ~clk_d;

  // Load FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Load FSM next state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en_rise) state_nxt = SHIFT;
      SHIFT:   if (!en_s)   state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load FSM control outputs; a load_clk edge coinciding with the en fall is dropped.
  always_comb begin
    start     = 1'b0;
    shift     = 1'b0;
    do_commit = 1'b0;
    bad_len   = 1'b0;
    unique case (state)
      IDLE:    start = en_rise;
      SHIFT:   shift = en_s & clk_rise;
      COMMIT: begin
        do_commit = (cnt == CNTW'(CFG_BITS));
        bad_len   = (cnt != CNTW'(CFG_BITS));
      end
      default: ;
    endcase
  end

  // Shadow shift register, bit counter, atomic commit and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      active      <= '0;
      cnt         <= '0;
      o_cfg_valid <= 1'b0;
      o_cfg_err   <= 1'b0;
    end else begin
      if (start) begin
        cnt       <= '0;
        o_cfg_err <= 1'b0;
`ifdef MINILOGIX2_READBACK_EN
        shadow    <= active;
`else
        shadow    <= '0;
`endif
      end
      if (shift) begin
        shadow <= {shadow[CFG_BITS-2:0], dat_s};
        if (cnt != CNTW'(CFG_BITS + 1)) cnt <= cnt + 1'b1;
      end
      if (do_commit) begin
        active      <= shadow;
        o_cfg_valid <= 1'b1;
      end
      if (bad_len) o_cfg_err <= 1'b1;
    end
  end

`ifdef MINILOGIX2_READBACK_EN
  assign o_load_dat = shadow[CFG_BITS-1];
`else
  assign o_load_dat = 1'b0;
`endif

  // Source pool padded to the full select range; out-of-range selects read i_input[0].
  always_comb begin
    src_pool           = {SPOOL{i_input[0]}};
    src_pool[NSRC-1:0] = {cell_q, i_input};
  end

  for (genvar c = 0; c < NCELL; c++) begin : g_cell
    logic [K*SELW-1:0] sel;
    logic [K-1:0]      src;
    for (genvar k = 0; k < K; k++) begin : g_src
      assign src[k] = src_pool[sel[k*SELW +: SELW]];
    end
    minilogix2_cell #(
      .K    (K),
      .SELW (SELW)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .src (src),
      .cfg (active[c*CB +: CB]),
      .sel (sel),
      .q   (cell_q[c]),
      .out (cell_out[c])
    );
  end

  assign out_pool = OPOOL'(cell_out);

  for (genvar j = 0; j < NOUT; j++) begin : g_out
    assign o_output[j] = out_pool[active[osel_lo(j, NCELL, CB, OSW) +: OSW]];
  end

endmodule

// File: doc/minilogix2.md
Name: minilogix2

Overview:
- Second-generation tiny field-programmable logic fabric for the TT tile: NCELL K-input LUT cells, each with an optional output flop, fed by a configurable input crossbar, plus an output mux onto NOUT pins.
- Configuration arrives over slow pin-driven serial lines (load_en/load_clk/load_dat) that are synchronised into clk.
- Configuration is double-buffered and committed atomically only after an exact-length load.
- Sits directly under the tile top; ui_in feeds i_input, uo_out is driven from o_output, and the load lines come from uio_in.

Parameters:
- NIN, 8: primary inputs.
- NOUT, 8: primary outputs.
- NCELL, 16: LUT cells.
- K, 3: LUT inputs per cell.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_input  in  NIN  primary inputs, used unsynchronised.
- o_output  out  NOUT  fabric outputs.
- i_load_en  in  1  async; high = load session active.
- i_load_clk  in  1  async serial config clock; rising edge shifts.
- i_load_dat  in  1  async serial config data.
- o_load_dat  out  1  readback data; 0 unless the readback feature is compiled in.
- o_cfg_valid  out  1  active configuration has been committed at least once since reset.
- o_cfg_err  out  1  sticky; last session had the wrong bit count.

Behaviour:
- Derived widths:
  - SELW = clog2(NIN+NCELL)
  - OSW = clog2(NCELL)
  - CB = K*SELW + 2^K + 1
  - CFG_BITS = NCELL*CB + NOUT*OSW
  - Defaults give SELW=5, OSW=4, CB=24, CFG_BITS=416.
- Config layout, in both shadow and active registers:
  - Cell c occupies [c*CB +: CB].
  - Within a cell: sel k at [k*SELW +: SELW]; truth table at [K*SELW +: 2^K]; ff_en at the top bit.
  - Output j sel at [NCELL*CB + j*OSW +: OSW].
- Cell sources:
  - Index < NIN selects i_input[idx]; NIN..NIN+NCELL-1 selects cell q[idx-NIN].
  - Any index beyond that range selects i_input[0].
  - Sources are flop q values only, so no combinational loops are possible.
- Cell evaluation:
  - LUT index bit k = source k; comb = truth[index].
  - q <= comb every clk.
  - Cell out = ff_en ? q : comb.
  - o_output[j] = out[osel[j]]; this is combinational from i_input when the cell is unregistered.
- Synchroniser: load_en, load_clk and load_dat each pass through 2 flops. The load_clk edge is detected on the synced value, so an edge takes effect 3 clk after the pin.
- FSM:
  - IDLE: on synced load_en rising, go to SHIFT; clear bit counter and o_cfg_err.
  - SHIFT: on a load_clk edge while synced load_en is high, shadow <= {shadow[CFG_BITS-2:0], dat}. The counter saturates at CFG_BITS+1. The first bit sent ends at the MSB.
  - SHIFT, on synced load_en falling: go to COMMIT. If a load_clk edge arrives in the same cycle as the fall, the edge is ignored.
  - COMMIT (1 cycle): if count == CFG_BITS, active <= shadow and o_cfg_valid <= 1. Otherwise active is unchanged and o_cfg_err <= 1. Then go to IDLE.
  - New active config affects outputs the cycle after COMMIT. Cell q values are not cleared on commit.
- Reset:
  - Clears active, shadow, all q, counter and sync flops; FSM goes to IDLE.
  - o_output=0 (cell 0 out = truth[..] = 0); o_cfg_valid=0, o_cfg_err=0, o_load_dat=0.
  - Reset mid-session aborts the session with no commit.

Optional Feature:
- Macro: MINILOGIX2_READBACK_EN.
- Defined:
  - On entry to SHIFT, shadow <= active.
  - o_load_dat = shadow MSB, so each shift exposes the next bit of the old config; a full 416-bit session reads out the current config while loading the new one.
- Undefined:
  - Shadow is cleared on entry to SHIFT.
  - o_load_dat is tied to 0.

Decomposition:
- Package minilogix2_pkg:
  - clog2 helper; functions for SELW, CB and CFG_BITS.
  - FSM state enum {IDLE, SHIFT, COMMIT}.
  - Field-offset functions (sel_lo, tt_lo, ffen_bit, osel_lo).
- Sub-module minilogix2_cell:
  - Inputs: K sources and its CB config slice.
  - Outputs: q, out.
  - Instantiated NCELL times via generate.

Test Plan:
- Comb AND:
  - Stimulus: load cell0 sel={0,1,0}, truth=0x88, ff_en=0; osel0=0; all else 0; 416 bits.
  - ui=0x03 -> o_output[0]=1 with zero latency; ui=0x01 -> 0; o_cfg_valid=1, o_cfg_err=0.
- Toggle:
  - Stimulus: cell0 sel={8,8,8} (own q), truth=0x01, ff_en=1; osel0=0.
  - o_output[0] alternates 1,0,1,... each clk after commit.
- Short load:
  - Stimulus: after a valid config, a session of 415 bits.
  - o_cfg_err=1; outputs still behave per the old config.
  - A following 416-bit session clears err.
- Long load: 417 bits -> o_cfg_err=1, no commit.
- Reset mid-session: assert rst after 200 bits -> o_output=0, o_cfg_valid=0; the next full load commits normally.
- Readback (macro defined): load pattern A, then load B -> o_load_dat bitstream during the B session equals A, MSB first.
